// File: rtl/instr_fetch32_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch32_pkg
// Shared definitions for the 32-bit instruction fetch unit: FSM state
// encoding, the default reset PC, MIPS-style opcode constants for the
// control-flow instructions and a branch-offset helper.
// ---------------------------------------------------------------------------
package instr_fetch32_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Opcode field values (instruction[31:26]) for control-flow instructions.
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    // Word-aligned, sign-extended byte offset of a 16-bit branch immediate.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch32_if.sv
// ---------------------------------------------------------------------------
// instr_fetch32_if
// Instruction-memory read port.
//   imem_req   : fetch unit -> memory, read request
//   imem_addr  : fetch unit -> memory, byte address of the requested word
//   imem_ready : memory -> fetch unit, imem_rdata is valid this cycle
//   imem_rdata : memory -> fetch unit, fetched instruction word
// master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface instr_fetch32_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch32_npc_calc.sv
// ---------------------------------------------------------------------------
// npc_calc
// Combinational next-PC selection for the held instruction.
//   link_addr   : pc+4 of the held instruction (sequential successor)
//   instruction : held instruction (immediate / jump index fields)
//   Read_data_1 : rs value, jr target
//   Branch, nBranch, Jmp, Jal, Jr, Zero : decoded control and ALU flag
//   next_pc     : selected successor address
// Priority: Jr, then Jmp/Jal, then taken branch, then pc+4.
// ---------------------------------------------------------------------------
module npc_calc
    import instr_fetch32_pkg::*;
(
    input  logic [31:0] link_addr,
    input  logic [31:0] instruction,
    input  logic [31:0] Read_data_1,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        Zero,
    output logic [31:0] next_pc
);

    logic branch_taken;
    logic unused_bits;

    assign branch_taken = (Branch && Zero) || (nBranch && !Zero);

    // Opcode and the byte-offset bits of rs are not address-relevant here.
    assign unused_bits = ^{instruction[31:26], Read_data_1[1:0]};

    always_comb begin
        if (Jr) begin
            next_pc = {Read_data_1[31:2], 2'b00};
        end else if (Jmp || Jal) begin
            next_pc = {link_addr[31:28], instruction[25:0], 2'b00};
        end else if (branch_taken) begin
            next_pc = link_addr + branch_offset(instruction[15:0]);
        end else begin
            next_pc = link_addr;
        end
    end

endmodule

// File: rtl/instr_fetch32.sv
// ---------------------------------------------------------------------------
// instr_fetch32
// Instruction fetch unit. Requests one word from instruction memory at pc,
// holds it for execution, then advances pc using the control inputs that
// accompany exec_done.
//   clock, reset_n : clock and asynchronous active-low reset
//   imem           : instruction-memory read port (master side)
//   instruction    : held instruction word
//   instr_valid    : held instruction awaits execution
//   exec_done      : held instruction finished; control inputs valid
//   Branch, nBranch, Jmp, Jal, Jr, Zero, Read_data_1 : next-PC controls
//   pc, link_addr  : current instruction address and pc+4
// ---------------------------------------------------------------------------
module instr_fetch32
    import instr_fetch32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   clock,
    input  logic                   reset_n,
    instr_fetch32_if.master        imem,
    output logic [31:0]            instruction,
    output logic                   instr_valid,
    input  logic                   exec_done,
    input  logic                   Branch,
    input  logic                   nBranch,
    input  logic                   Jmp,
    input  logic                   Jal,
    input  logic                   Jr,
    input  logic                   Zero,
    input  logic [31:0]            Read_data_1,
    output logic [31:0]            pc,
    output logic [31:0]            link_addr
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  next_pc;

    assign link_addr      = pc + 32'd4;
    assign imem.imem_addr = pc;

    npc_calc u_npc_calc (
        .link_addr   (link_addr),
        .instruction (instruction),
        .Read_data_1 (Read_data_1),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jr          (Jr),
        .Zero        (Zero),
        .next_pc     (next_pc)
    );

    // State register.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (imem.imem_ready) state_next = HOLD;
            HOLD:    if (exec_done)       state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Output logic.
    // NOTE: defaults first so every path assigns each output (no latch).
    always_comb begin
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        case (state)
            FETCH:   imem.imem_req = 1'b1;
            HOLD:    instr_valid   = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers: memory data is only captured in FETCH and the
    // control inputs only matter on exec_done in HOLD, so both stay stable
    // for the whole HOLD period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            instruction <= 32'h0;
        end else begin
            if (state == FETCH && imem.imem_ready) begin
                instruction <= imem.imem_rdata;
            end
            if (state == HOLD && exec_done) begin
                pc <= next_pc;
            end
        end
    end

endmodule

// File: doc/instr_fetch32.md
INSTR_FETCH32 -- requirements
Module: instr_fetch32

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the PC value loaded at reset.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  byte address of the requested word; always equals pc.
REQ-006 imem_ready  input  1  memory returns imem_rdata this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instruction  output  32  held instruction; bits[31:26] feed the controller Opcode input, bits[5:0] feed Function_opcode.
REQ-009 instr_valid  output  1  instruction is valid and awaiting execution.
REQ-010 exec_done  input  1  downstream has finished executing the held instruction and its branch/jump inputs are valid.
REQ-011 Branch, nBranch, Jmp, Jal, Jr  input  1 each  decoded control for the held instruction.
REQ-012 Zero  input  1  ALU zero flag for the held instruction.
REQ-013 Read_data_1  input  32  rs register value, used as the jr target.
REQ-014 pc  output  32  address of the held or in-flight instruction.
REQ-015 link_addr  output  32  pc+4, the jal return address.

Function
REQ-016 The FSM SHALL have three states: IDLE, FETCH and HOLD.
REQ-017 The FSM SHALL move from IDLE to FETCH unconditionally on the first clock after reset release.
REQ-018 In FETCH: imem_req=1; on imem_ready=1, latch imem_rdata into instruction and go to HOLD; otherwise stay in FETCH.
REQ-019 In HOLD: instr_valid=1, imem_req=0; on exec_done=1, load next_pc into pc and go to FETCH; otherwise hold.
REQ-020 instr_valid SHALL be 1 only in HOLD; imem_req SHALL be 1 only in FETCH.
REQ-021 imem_ready outside FETCH SHALL be ignored, with no change to instruction.
REQ-022 exec_done outside HOLD SHALL be ignored.
REQ-023 Latency: imem_ready at cycle N gives instr_valid=1 at N+1; exec_done at cycle M gives a new pc and imem_req=1 at M+1.
REQ-024 Minimum throughput: one instruction per 2 cycles (imem_ready and exec_done each tied to 1).
REQ-025 next_pc priority: Jr, then (Jmp or Jal), then taken branch, then pc+4.
REQ-026 Jr target = {Read_data_1[31:2], 2'b00}.
REQ-027 Jump target = {link_addr[31:28], instruction[25:0], 2'b00}.
REQ-028 Branch target = link_addr + (sign-extended instruction[15:0] << 2), modulo 2^32.
REQ-029 Branch is taken when (Branch and Zero) or (nBranch and not Zero).
REQ-030 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC goes to 32'h0000_0000).
REQ-031 Control inputs SHALL be sampled only in the cycle exec_done=1 in HOLD.
REQ-032 Simultaneous Jr and Jmp SHALL resolve as Jr.
REQ-033 instruction, pc and link_addr SHALL stay stable throughout HOLD.

Reset
REQ-034 reset_n=0 SHALL take effect immediately, independent of clock, setting:
  - state=IDLE, pc=RESET_PC, instruction=32'h0;
  - imem_req=0, instr_valid=0, link_addr=RESET_PC+4.
REQ-035 Reset asserted mid-FETCH or mid-HOLD SHALL abort the operation; a pending imem_ready or exec_done SHALL have no effect.
REQ-036 After release, the first request SHALL be issued from RESET_PC.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, the RESET_PC default, and the opcode constants for j, jal, beq and bne.
REQ-038 Next-PC selection SHALL be a combinational sub-module, npc_calc; the FSM and registers stay in instr_fetch32.

Verification
REQ-039 Reset release with imem_ready=1 -> imem_addr=0x0 and imem_req=1 at cycle 2; instr_valid=1 at cycle 3.
REQ-040 Sequential: exec_done with no control set at pc=0x10 -> next imem_addr=0x14.
REQ-041 beq with Zero=1, imm=16'hFFFF at pc=0x20 -> next pc=0x20; same with Zero=0 -> 0x24; bne with Zero=0, imm=0x0002 -> 0x2C.
REQ-042 jal with instr[25:0]=0x000_0040 at pc=0x0040_0000 -> link_addr=0x0040_0004, next pc=0x0000_0100; Jr with Read_data_1=0x1237 -> next pc=0x1234.
REQ-043 imem_ready held low for 5 cycles -> imem_req stays 1 and instr_valid stays 0; exec_done pulses during FETCH -> ignored, pc unchanged.
REQ-044 reset_n asserted mid-HOLD at pc=0x80 -> pc=0x0 and instr_valid=0 immediately; wrap case: pc=0xFFFF_FFFC sequential -> next pc=0x0.
